// File: rtl/anim_pkg.sv
// Shared types and tables for the sprite-animation sequencer: movement states,
// the koopa sprite-sheet layout, and helpers for slicing packed per-animation buses.
package anim_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      JUMP = 2'd2,
      RSVD = 2'd3
   } movement_state_t;

   // Koopa sheet layout, one entry per movement_state (reserved entry unused).
   localparam int          KOOPA_STRIDE       = 46;
   localparam int          KOOPA_BASE_ROW [4] = '{0, 48, 96, 0};
   localparam int          KOOPA_BASE_COL [4] = '{0, 0, 0, 0};
   localparam int          KOOPA_LAST     [4] = '{1, 3, 2, 0};
   localparam int          KOOPA_HOLD     [4] = '{7, 3, 2, 0};
   localparam logic [3:0]  KOOPA_LOOP         = 4'b0011;

   // Bit position of field idx in a bus of back-to-back width-bit fields.
   function automatic int unsigned field_lsb(int unsigned idx, int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/anim_frame_counter.sv
// Frame stepper for one animation: hold counting, frame advance, loop wrap
// pulse and sticky one-shot done flag.
module anim_frame_counter
   import anim_pkg::*;
#(
   parameter int FRAME_W = 3,
   parameter int HOLD_W  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               restart,
   input  logic [FRAME_W-1:0] last,
   input  logic [HOLD_W-1:0]  hold,
   input  logic               loop,
   output logic [FRAME_W-1:0] frame,
   output logic               done,
   output logic               wrap
);

   logic [HOLD_W-1:0] hold_cnt;

   // NOTE: state registers use non-blocking assignments so every update in
   // this block reads the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame    <= '0;
         hold_cnt <= '0;
         done     <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (restart) begin
            frame    <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
         end else if (tick && !done) begin
            if (hold_cnt < hold) begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
               hold_cnt <= '0;
               // frame beyond a shrunken last is treated as the last frame
               if (frame < last) begin
                  frame <= frame + FRAME_W'(1);
               end else if (loop) begin
                  frame <= '0;
                  wrap  <= 1'b1;
               end else begin
                  done <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/anim_sequencer.sv
// Table-driven sprite-animation sequencer: tracks the selected animation,
// restarts on selection change and maps the current frame to sheet coordinates.
module anim_sequencer
   import anim_pkg::*;
#(
   parameter int  NUM_ANIMS  = 4,
   parameter int  MAX_FRAMES = 8,
   parameter int  HOLD_W     = 4,
   parameter int  ROW_W      = 11,
   parameter int  COL_W      = 11,
   localparam int SEL_W      = $clog2(NUM_ANIMS),
   localparam int FRAME_W    = $clog2(MAX_FRAMES)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         anim_tick,
   input  logic                         pause,
   input  logic [SEL_W-1:0]             anim_sel,
   input  logic [NUM_ANIMS*FRAME_W-1:0] cfg_last,
   input  logic [NUM_ANIMS*HOLD_W-1:0]  cfg_hold,
   input  logic [NUM_ANIMS-1:0]         cfg_loop,
   input  logic [NUM_ANIMS*ROW_W-1:0]   cfg_base_row,
   input  logic [NUM_ANIMS*COL_W-1:0]   cfg_base_col,
   input  logic [NUM_ANIMS*COL_W-1:0]   cfg_stride,
   output logic [ROW_W-1:0]             anim_row,
   output logic [COL_W-1:0]             anim_col,
   output logic [COL_W-1:0]             max_width,
   output logic [FRAME_W-1:0]           frame_idx,
   output logic                         anim_done,
   output logic                         frame_wrap
);

   logic [FRAME_W-1:0] last_tab   [NUM_ANIMS];
   logic [HOLD_W-1:0]  hold_tab   [NUM_ANIMS];
   logic [ROW_W-1:0]   row_tab    [NUM_ANIMS];
   logic [COL_W-1:0]   col_tab    [NUM_ANIMS];
   logic [COL_W-1:0]   stride_tab [NUM_ANIMS];

   for (genvar g = 0; g < NUM_ANIMS; g++) begin : g_unpack
      assign last_tab[g]   = cfg_last[field_lsb(g, FRAME_W) +: FRAME_W];
      assign hold_tab[g]   = cfg_hold[field_lsb(g, HOLD_W) +: HOLD_W];
      assign row_tab[g]    = cfg_base_row[field_lsb(g, ROW_W) +: ROW_W];
      assign col_tab[g]    = cfg_base_col[field_lsb(g, COL_W) +: COL_W];
      assign stride_tab[g] = cfg_stride[field_lsb(g, COL_W) +: COL_W];
   end

   logic [SEL_W-1:0] cur_sel;
   logic             restart;
   logic             tick;

   assign restart = (anim_sel != cur_sel);
   assign tick    = anim_tick && !pause;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_sel <= '0;
      end else if (restart) begin
         cur_sel <= anim_sel;
      end
   end

   anim_frame_counter #(
      .FRAME_W (FRAME_W),
      .HOLD_W  (HOLD_W)
   ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .restart (restart),
      .last    (last_tab[cur_sel]),
      .hold    (hold_tab[cur_sel]),
      .loop    (cfg_loop[cur_sel]),
      .frame   (frame_idx),
      .done    (anim_done),
      .wrap    (frame_wrap)
   );

   // Column wraps modulo 2**COL_W; the sheet layout keeps strips in range.
   assign anim_row  = row_tab[cur_sel];
   assign anim_col  = col_tab[cur_sel]
                    + {{(COL_W-FRAME_W){1'b0}}, frame_idx} * stride_tab[cur_sel];
   assign max_width = stride_tab[cur_sel];

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer: each scenario queues expected output
// snapshots as it drives stimulus and compares them against sampled DUT outputs.
module tb_anim_sequencer;
   import anim_pkg::*;

   localparam int NA = 4;
   localparam int FW = 3;
   localparam int HW = 4;
   localparam int RW = 11;
   localparam int CW = 11;

   typedef struct packed {
      logic [FW-1:0] frame;
      logic [RW-1:0] row;
      logic [CW-1:0] col;
      logic [CW-1:0] width;
      logic          done;
      logic          wrap;
   } snap_t;

   logic              clk;
   logic              reset;
   logic              anim_tick;
   logic              pause;
   logic [1:0]        anim_sel;
   logic [NA*FW-1:0]  cfg_last;
   logic [NA*HW-1:0]  cfg_hold;
   logic [NA-1:0]     cfg_loop;
   logic [NA*RW-1:0]  cfg_base_row;
   logic [NA*CW-1:0]  cfg_base_col;
   logic [NA*CW-1:0]  cfg_stride;
   logic [RW-1:0]     anim_row;
   logic [CW-1:0]     anim_col;
   logic [CW-1:0]     max_width;
   logic [FW-1:0]     frame_idx;
   logic              anim_done;
   logic              frame_wrap;

   logic [FW-1:0] last_a   [NA];
   logic [HW-1:0] hold_a   [NA];
   logic          loop_a   [NA];
   logic [RW-1:0] row_a    [NA];
   logic [CW-1:0] col_a    [NA];
   logic [CW-1:0] stride_a [NA];

   for (genvar i = 0; i < NA; i++) begin : g_cfg
      assign cfg_last[i*FW +: FW]     = last_a[i];
      assign cfg_hold[i*HW +: HW]     = hold_a[i];
      assign cfg_loop[i]              = loop_a[i];
      assign cfg_base_row[i*RW +: RW] = row_a[i];
      assign cfg_base_col[i*CW +: CW] = col_a[i];
      assign cfg_stride[i*CW +: CW]   = stride_a[i];
   end

   anim_sequencer #(
      .NUM_ANIMS  (NA),
      .MAX_FRAMES (8),
      .HOLD_W     (HW),
      .ROW_W      (RW),
      .COL_W      (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .anim_tick    (anim_tick),
      .pause        (pause),
      .anim_sel     (anim_sel),
      .cfg_last     (cfg_last),
      .cfg_hold     (cfg_hold),
      .cfg_loop     (cfg_loop),
      .cfg_base_row (cfg_base_row),
      .cfg_base_col (cfg_base_col),
      .cfg_stride   (cfg_stride),
      .anim_row     (anim_row),
      .anim_col     (anim_col),
      .max_width    (max_width),
      .frame_idx    (frame_idx),
      .anim_done    (anim_done),
      .frame_wrap   (frame_wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   snap_t exp_q[$];
   snap_t obs_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   // Expected snapshot from the bench's own copy of the sheet configuration.
   task automatic expect_out(input int sel, input int frame, input bit done, input bit wrap);
      snap_t s;
      s.frame = FW'(frame);
      s.row   = row_a[sel];
      s.col   = CW'(int'(col_a[sel]) + frame * int'(stride_a[sel]));
      s.width = stride_a[sel];
      s.done  = done;
      s.wrap  = wrap;
      exp_q.push_back(s);
   endtask

   task automatic sample();
      snap_t s;
      s.frame = frame_idx;
      s.row   = anim_row;
      s.col   = anim_col;
      s.width = max_width;
      s.done  = anim_done;
      s.wrap  = frame_wrap;
      obs_q.push_back(s);
   endtask

   // Drives anim_tick for one clock, then samples 1 time unit after the edge.
   task automatic cycle(input bit t);
      anim_tick = t;
      @(posedge clk);
      #1;
      anim_tick = 1'b0;
      sample();
   endtask

   task automatic test_reset();
      snap_t e, o;
      int    idx = 0;
      #3;
      sample();
      expect_out(IDLE, 0, 0, 0);
      @(posedge clk);
      #1;
      sample();
      expect_out(IDLE, 0, 0, 0);
      reset = 1'b0;
      cycle(0);
      expect_out(IDLE, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL reset#%0d: no sample taken, required frame=%0d", idx, e.frame);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL reset#%0d: got frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b, required frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b",
                        idx, o.frame, o.row, o.col, o.width, o.done, o.wrap,
                        e.frame, e.row, e.col, e.width, e.done, e.wrap);
            end
         end
         idx++;
      end
   endtask

   task automatic test_loop();
      snap_t e, o;
      int    idx = 0;
      for (int k = 1; k <= 9; k++) begin
         cycle(1);
         expect_out(IDLE, (k / 2) % 4, 0, k == 8);
         cycle(0);
         expect_out(IDLE, (k / 2) % 4, 0, 0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL loop#%0d: no sample taken, required frame=%0d", idx, e.frame);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL loop#%0d: got frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b, required frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b",
                        idx, o.frame, o.row, o.col, o.width, o.done, o.wrap,
                        e.frame, e.row, e.col, e.width, e.done, e.wrap);
            end
         end
         idx++;
      end
   endtask

   task automatic test_oneshot();
      snap_t e, o;
      int    idx = 0;
      anim_sel = JUMP;
      cycle(0);
      expect_out(JUMP, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         cycle(1);
         expect_out(JUMP, (k < 2) ? k : 2, k >= 3, 0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL oneshot#%0d: no sample taken, required frame=%0d", idx, e.frame);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL oneshot#%0d: got frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b, required frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b",
                        idx, o.frame, o.row, o.col, o.width, o.done, o.wrap,
                        e.frame, e.row, e.col, e.width, e.done, e.wrap);
            end
         end
         idx++;
      end
   endtask

   task automatic test_restart_tick();
      snap_t e, o;
      int    idx = 0;
      anim_sel = WALK;
      cycle(0);
      expect_out(WALK, 0, 0, 0);
      cycle(1);
      expect_out(WALK, 1, 0, 0);
      anim_sel = JUMP;
      cycle(1);
      expect_out(JUMP, 0, 0, 0);
      cycle(0);
      expect_out(JUMP, 0, 0, 0);
      cycle(1);
      expect_out(JUMP, 1, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL restart_tick#%0d: no sample taken, required frame=%0d", idx, e.frame);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL restart_tick#%0d: got frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b, required frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b",
                        idx, o.frame, o.row, o.col, o.width, o.done, o.wrap,
                        e.frame, e.row, e.col, e.width, e.done, e.wrap);
            end
         end
         idx++;
      end
   endtask

   task automatic test_pause();
      snap_t e, o;
      int    idx = 0;
      anim_sel = IDLE;
      cycle(0);
      expect_out(IDLE, 0, 0, 0);
      cycle(1);
      expect_out(IDLE, 0, 0, 0);
      cycle(1);
      expect_out(IDLE, 1, 0, 0);
      cycle(1);
      expect_out(IDLE, 1, 0, 0);
      pause = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle(1);
         expect_out(IDLE, 1, 0, 0);
      end
      pause = 1'b0;
      cycle(1);
      expect_out(IDLE, 2, 0, 0);
      pause = 1'b1;
      cycle(1);
      expect_out(IDLE, 2, 0, 0);
      anim_sel = WALK;
      cycle(1);
      expect_out(WALK, 0, 0, 0);
      pause = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL pause#%0d: no sample taken, required frame=%0d", idx, e.frame);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL pause#%0d: got frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b, required frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b",
                        idx, o.frame, o.row, o.col, o.width, o.done, o.wrap,
                        e.frame, e.row, e.col, e.width, e.done, e.wrap);
            end
         end
         idx++;
      end
   endtask

   task automatic test_shrink();
      snap_t e, o;
      int    idx = 0;
      anim_sel = RSVD;
      cycle(0);
      expect_out(RSVD, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         cycle(1);
         expect_out(RSVD, k, 0, 0);
      end
      last_a[RSVD] = 3'd1;
      cycle(1);
      expect_out(RSVD, 0, 0, 1);
      cycle(0);
      expect_out(RSVD, 0, 0, 0);
      last_a[RSVD] = 3'd5;
      loop_a[RSVD] = 1'b0;
      anim_sel = IDLE;
      cycle(0);
      expect_out(IDLE, 0, 0, 0);
      anim_sel = RSVD;
      cycle(0);
      expect_out(RSVD, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         cycle(1);
         expect_out(RSVD, k, 0, 0);
      end
      last_a[RSVD] = 3'd1;
      cycle(1);
      expect_out(RSVD, 4, 1, 0);
      loop_a[RSVD] = 1'b1;
      cycle(1);
      expect_out(RSVD, 4, 1, 0);
      cycle(1);
      expect_out(RSVD, 4, 1, 0);
      last_a[RSVD] = 3'd5;
      anim_sel = WALK;
      cycle(0);
      expect_out(WALK, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL shrink#%0d: no sample taken, required frame=%0d", idx, e.frame);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL shrink#%0d: got frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b, required frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b",
                        idx, o.frame, o.row, o.col, o.width, o.done, o.wrap,
                        e.frame, e.row, e.col, e.width, e.done, e.wrap);
            end
         end
         idx++;
      end
   endtask

   task automatic test_async_reset();
      snap_t e, o;
      int    idx = 0;
      anim_sel = JUMP;
      cycle(0);
      expect_out(JUMP, 0, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         cycle(1);
         expect_out(JUMP, (k < 2) ? k : 2, k >= 3, 0);
      end
      #2;
      reset = 1'b1;
      #1;
      sample();
      expect_out(IDLE, 0, 0, 0);
      anim_sel = IDLE;
      #2;
      reset = 1'b0;
      cycle(1);
      expect_out(IDLE, 0, 0, 0);
      cycle(1);
      expect_out(IDLE, 1, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL async_reset#%0d: no sample taken, required frame=%0d", idx, e.frame);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL async_reset#%0d: got frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b, required frame=%0d row=%0d col=%0d width=%0d done=%b wrap=%b",
                        idx, o.frame, o.row, o.col, o.width, o.done, o.wrap,
                        e.frame, e.row, e.col, e.width, e.done, e.wrap);
            end
         end
         idx++;
      end
   endtask

   initial begin
      reset     = 1'b1;
      anim_tick = 1'b0;
      pause     = 1'b0;
      anim_sel  = IDLE;
      row_a    = '{11'd0, 11'd100, 11'd200, 11'd300};
      col_a    = '{11'd0, 11'd10, 11'd20, 11'd30};
      stride_a = '{11'd46, 11'd46, 11'd46, 11'd40};
      last_a   = '{3'd3, 3'd5, 3'd2, 3'd5};
      hold_a   = '{4'd1, 4'd0, 4'd0, 4'd0};
      loop_a   = '{1'b1, 1'b1, 1'b0, 1'b1};

      test_reset();
      test_loop();
      test_oneshot();
      test_restart_tick();
      test_pause();
      test_shrink();
      test_async_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
Parametrised sprite-animation sequencer that replaces per-animation frame FSMs with one table-driven engine. It selects one of NUM_ANIMS animations, steps frames on anim_tick with a per-animation hold count, and supports loop or one-shot modes. It restarts on any selection change, detected at clk rate, and outputs the sprite-sheet row/col and frame width for the pattern generator.

Parameters:
NUM_ANIMS, 4, number of animations selectable (SEL_W = $clog2(NUM_ANIMS))
MAX_FRAMES, 8, max frames per animation (FRAME_W = $clog2(MAX_FRAMES))
HOLD_W, 4, width of per-animation hold count
ROW_W, 11, sprite-sheet row coordinate width
COL_W, 11, sprite-sheet column coordinate width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
anim_tick  in  1  one-clk-wide strobe in clk domain; frame-rate time base
pause  in  1  when high, anim_tick is ignored
anim_sel  in  SEL_W  requested animation (movement_state cast)
cfg_last  in  NUM_ANIMS*FRAME_W  per-animation last frame index (frame count - 1)
cfg_hold  in  NUM_ANIMS*HOLD_W  per-animation extra ticks per frame (frame shown hold+1 ticks)
cfg_loop  in  NUM_ANIMS  1 = loop, 0 = one-shot
cfg_base_row  in  NUM_ANIMS*ROW_W  sheet row of animation strip
cfg_base_col  in  NUM_ANIMS*COL_W  sheet col of frame 0
cfg_stride  in  NUM_ANIMS*COL_W  frame width in pixels
anim_row  out  ROW_W  current frame row
anim_col  out  COL_W  current frame col
max_width  out  COL_W  current frame width
frame_idx  out  FRAME_W  current frame index
anim_done  out  1  level: one-shot animation finished
frame_wrap  out  1  one-clk pulse: loop animation wrapped to frame 0

Behaviour:
- Registered state: cur_sel, frame, hold_cnt, done, wrap. Reset values are all 0, so anim_row = cfg_base_row[0] and anim_col = cfg_base_col[0].
- Outputs are combinational from registered state, indexed by cur_sel: anim_row = base_row; anim_col = base_col + frame*stride, truncated to COL_W, no saturation; max_width = stride.
- Restart, every clk: if anim_sel != cur_sel, then cur_sel<=anim_sel, frame<=0, hold_cnt<=0, done<=0. Outputs change on the next cycle.
- Restart has priority over a coincident anim_tick; that tick is dropped.
- Restart applies even while pause=1 or done=1.
- Advance: anim_tick && !pause && !restart && !done:
  - If hold_cnt < cfg_hold, then hold_cnt++.
  - Else (expiry) hold_cnt<=0 and:
    - frame < last: frame++.
    - frame >= last, loop mode: frame<=0, frame_wrap=1 for 1 cycle.
    - frame >= last, one-shot: frame stays, done<=1.
- Clamp rule: frame >= last is treated as last. This covers cfg_last shrinking mid-animation.
- cfg_last = 0: single frame. In loop mode frame_wrap pulses at every expiry; in one-shot, done sets at the first expiry.
- One-shot done is held until a restart or reset; further ticks are ignored.
- Changing cfg_loop from 0 to 1 while done=1 has no effect until restart.
- frame_wrap defaults to 0 every cycle it is not set.
- Async reset mid-animation returns all state to reset values immediately. The first tick after reset release starts hold counting for frame 0.
- The cfg_* buses are quasi-static (written by the top level); they are not registered here.

Decomposition:
- Package anim_pkg holds:
  - movement_state enum (IDLE=0, WALK=1, JUMP=2, reserved 3), used to drive anim_sel
  - localparams for the koopa sheet tables (base row/col, stride 46, last, hold, loop per state)
  - helper functions to slice the packed cfg buses
- Sub-module anim_frame_counter holds hold_cnt, frame, done and wrap. Inputs: tick, restart, last, hold, loop. The top level handles selection and row/col arithmetic.

Test Plan:
- Reset with sel=IDLE, base_col[0]=0, stride=46, last=3, hold=1, loop=1; 8 ticks -> frame 0,0,1,1,2,2,3,3; col 0,0,46,46,92,92,138,138; 9th tick -> frame 0, frame_wrap pulse.
- JUMP one-shot: last=2, hold=0; 5 ticks -> frame 0,1,2; done=1 on the 3rd tick and stays high; frame remains 2.
- Switch WALK->JUMP on the same cycle as anim_tick -> next cycle frame=0, hold_cnt=0, tick dropped; row = base_row[JUMP].
- pause=1 for 4 ticks at frame 1 -> frame and hold frozen; sel change during pause -> frame=0.
- cfg_last changed 5->1 while frame=4, loop -> next expiry gives frame 0 with wrap pulse; one-shot -> done=1, frame=4.
- Assert reset asynchronously mid-hold (no clk edge) -> outputs immediately at reset values; done=0, frame_wrap=0.
